// File: rtl/bcd_converter.sv
// Sequential 14-bit binary to 4-digit BCD converter (double-dabble, one bit per clock).
// Define BCD_SATURATE_EN to clamp the digits to 9999 when the value exceeds 9999.

module bcd_add3 (
    input  logic [3:0] nib_in,
    output logic [3:0] nib_out
);
    assign nib_out = (nib_in >= 4'd5) ? nib_in + 4'd3 : nib_in;
endmodule

module bcd_converter #(
    parameter int IN_W = 14
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [IN_W-1:0] bin,
    output logic            busy,
    output logic            done,
    output logic            ovf,
    output logic [3:0]      digit1,
    output logic [3:0]      digit2,
    output logic [3:0]      digit3,
    output logic [3:0]      digit4
);
    localparam int NUM_DIG = 5;
    localparam int SR_W    = IN_W + 4 * NUM_DIG;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state, state_nxt;
    logic [SR_W-1:0] sr, sr_adj;
    logic [3:0]      cnt;

    // Add-3 correction on every BCD nibble before each shift
    assign sr_adj[IN_W-1:0] = sr[IN_W-1:0];
    for (genvar g = 0; g < NUM_DIG; g++) begin : g_nib
        bcd_add3 u_add3 (
            .nib_in  (sr[IN_W + 4*g +: 4]),
            .nib_out (sr_adj[IN_W + 4*g +: 4])
        );
    end

    // done stays part of busy so the accepting edge through the result edge read as busy
    assign busy = (state != IDLE) || done;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt == 4'd1) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sr     <= '0;
            cnt    <= '0;
            done   <= 1'b0;
            ovf    <= 1'b0;
            digit1 <= '0;
            digit2 <= '0;
            digit3 <= '0;
            digit4 <= '0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sr  <= SR_W'(bin);
                        cnt <= 4'(IN_W);
                    end
                end
                SHIFT: begin
                    sr  <= sr_adj << 1;
                    cnt <= cnt - 4'd1;
                end
                DONE: begin
                    done <= 1'b1;
                    ovf  <= |sr[IN_W + 16 +: 4];
`ifdef BCD_SATURATE_EN
                    if (|sr[IN_W + 16 +: 4]) begin
                        digit1 <= 4'd9;
                        digit2 <= 4'd9;
                        digit3 <= 4'd9;
                        digit4 <= 4'd9;
                    end else begin
                        digit1 <= sr[IN_W      +: 4];
                        digit2 <= sr[IN_W + 4  +: 4];
                        digit3 <= sr[IN_W + 8  +: 4];
                        digit4 <= sr[IN_W + 12 +: 4];
                    end
`else
                    digit1 <= sr[IN_W      +: 4];
                    digit2 <= sr[IN_W + 4  +: 4];
                    digit3 <= sr[IN_W + 8  +: 4];
                    digit4 <= sr[IN_W + 12 +: 4];
`endif
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_converter.sv
// Scoreboard bench for bcd_converter: expected digits queued at start, checked on done.

module tb_bcd_converter;
    logic        clk = 1'b0;
    logic        rst, start;
    logic [13:0] bin;
    logic        busy, done, ovf;
    logic [3:0]  digit1, digit2, digit3, digit4;

    int checks = 0;
    int fails  = 0;
    logic [16:0] sb_q[$];

    bcd_converter #(.IN_W(14)) dut (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(busy), .done(done), .ovf(ovf),
        .digit1(digit1), .digit2(digit2), .digit3(digit3), .digit4(digit4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            fails++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // {ovf, thousands, hundreds, tens, ones}
    function automatic logic [16:0] exp_of(input int v);
        logic o;
        int   m;
        o = (v > 9999);
        m = v % 10000;
`ifdef BCD_SATURATE_EN
        if (o) m = 9999;
`endif
        return {o, 4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    function automatic int obs_res();
        return int'({ovf, digit4, digit3, digit2, digit1});
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb_q.size() == 0) chk("unexpected_done", 1, 0);
            else chk("result", obs_res(), int'(sb_q.pop_front()));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Start one conversion, wait (bounded) for done, then one idle cycle
    task automatic convert(input int v);
        bit seen;
        seen = 0;
        @(negedge clk);
        start = 1'b1;
        bin   = 14'(v);
        sb_q.push_back(exp_of(v));
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (done) seen = 1;
            else @(negedge clk);
        end
        if (!seen) chk("done_timeout", 0, 1);
        @(negedge clk);
    endtask

    initial begin
        int bc, dc, di, nd;
        int dt[3];
        rst = 1'b1; start = 1'b0; bin = '0;
        tick(3);
        chk("reset_outs", {busy, done, obs_res()}, 0);
        rst = 1'b0;
        tick(1);

        // bin=30: timing of busy/done relative to the accepting edge
        start = 1'b1; bin = 14'd30;
        sb_q.push_back(exp_of(30));
        @(negedge clk);
        start = 1'b0;
        bc = 0; dc = 0; di = -1;
        for (int i = 0; i < 40; i++) begin
            if (busy) bc++;
            if (done) begin dc++; di = i; end
            @(negedge clk);
        end
        chk("busy_cycles", bc, 16);
        chk("done_count", dc, 1);
        chk("done_latency", di, 15);

        convert(0);
        convert(9999);
        convert(16383);

        // start during SHIFT is ignored; bin change after acceptance has no effect
        @(negedge clk);
        start = 1'b1; bin = 14'd1234;
        sb_q.push_back(exp_of(1234));
        @(negedge clk);
        start = 1'b0; bin = 14'd777;
        tick(4);
        start = 1'b1; bin = 14'd4321;
        @(negedge clk);
        start = 1'b0;
        tick(2);
        chk("digits_held", obs_res(), int'(exp_of(16383)));
        dc = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) dc++;
            @(negedge clk);
        end
        chk("single_done", dc, 1);

        // reset mid-conversion aborts without a done pulse
        convert(5678);
        start = 1'b1; bin = 14'd4321;
        @(negedge clk);
        start = 1'b0;
        tick(6);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_outs", {busy, done, obs_res()}, 0);
        dc = 0;
        for (int i = 0; i < 25; i++) begin
            if (done) dc++;
            @(negedge clk);
        end
        chk("abort_no_done", dc, 0);
        convert(4321);

        // reset wins over start on the same edge
        rst = 1'b1; start = 1'b1; bin = 14'd55;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_beats_start", {busy, done}, 0);

        // start held high: one conversion every 16 clocks
        start = 1'b1; bin = 14'd256;
        repeat (3) sb_q.push_back(exp_of(256));
        nd = 0;
        for (int i = 0; i < 80 && nd < 3; i++) begin
            @(negedge clk);
            if (done) begin dt[nd] = i; nd++; end
        end
        start = 1'b0;
        chk("b2b_done_count", nd, 3);
        if (nd == 3) begin
            chk("b2b_gap1", dt[1] - dt[0], 16);
            chk("b2b_gap2", dt[2] - dt[1], 16);
        end
        tick(30);
        chk("sb_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/bcd_converter.md
# bcd_converter

Sequential binary-to-BCD converter that sits between the multiplier and the four-digit seven-segment display driver. It accepts the 14-bit magnitude produced by the multiplier, converts it with a shift-and-add-3 (double-dabble) algorithm at one bit per clock, and presents four held BCD digits that feed the display's digit inputs. Sign handling stays with the multiplier and display; this block converts magnitude only.

## Interface
- `IN_W`, 14, width of the binary input; fixed at 14 for this design. Other values are not supported.
- `clk`  in  1  system clock; all logic updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a conversion; sampled only in IDLE.
- `bin`  in  14  unsigned binary value (multiplier `result`); captured on the accepting edge.
- `busy`  out  1  high while a conversion is in progress.
- `done`  out  1  one-cycle pulse; digits are valid and updated.
- `ovf`  out  1  value exceeded 9999 on the last conversion; held until the next conversion completes.
- `digit1`  out  4  BCD ones.
- `digit2`  out  4  BCD tens.
- `digit3`  out  4  BCD hundreds.
- `digit4`  out  4  BCD thousands.

## Operation
- The block is a 3-state FSM with states IDLE, SHIFT and DONE.
- **IDLE**
  - When `start`=1, load `bin` into the low 14 bits of a 34-bit shift register and clear the upper 20 BCD bits (5 digits).
  - Set the iteration counter to 14 and go to SHIFT.
  - When `start`=0, stay in IDLE.
- **SHIFT**, one iteration per clock:
  - For each of the 5 BCD nibbles, add 3 if the nibble is ≥5.
  - Then shift the whole register left by 1.
  - Decrement the counter. After the 14th iteration, go to DONE.
- **DONE**, one cycle:
  - Register the digits and `ovf`, pulse `done`, then return to IDLE.
- `ovf`=1 when the ten-thousands nibble is non-zero, i.e. the value is ≥10000. The maximum input, 16383, needs 5 digits.
- `start` is ignored in SHIFT and DONE; nothing is queued.
- Output digits hold their last completed value during a conversion. The display never sees intermediate values.
- An input of 0 gives all digits 0 and `ovf`=0.

## Timing
- Call the edge that samples `start`=1 in IDLE edge E0.
  - E1..E14 perform the 14 iterations.
  - At E15 the digits and `ovf` update and `done` goes high.
  - At E16 `done` falls and the state is back in IDLE.
- Latency is 15 clocks from the accepting edge to valid digits.
- `busy` is high from E0 through E15 inclusive, and low when `done` is low and the state is IDLE.
- The earliest next accepted `start` is the one sampled at E16, which gives a throughput of one conversion per 16 clocks.
- `bin` is only sampled at E0. Changes to `bin` after E0 do not affect the conversion in flight.
- Reset values: `busy`=0, `done`=0, `ovf`=0, `digit1`..`digit4`=0, FSM in IDLE, counter 0.
- Reset asserted mid-conversion aborts it at that edge. No `done` pulse is produced and the outputs return to their reset values.
- If `rst` and `start` are high on the same edge, reset wins.

## Configuration
- `BCD_SATURATE_EN`
  - **Defined:** when `ovf`=1, the outputs saturate to 9,9,9,9 (`digit4`..`digit1`).
  - **Undefined:** the outputs are the low four decimal digits (value mod 10000).
- `ovf` is generated identically in both builds.

## Test plan
- `bin`=30 (3×10 product), single `start` pulse → at E15 `digit4`..`digit1` = 0,0,3,0, `ovf`=0, `done` high for exactly one cycle, `busy` high for 16 cycles.
- `bin`=0, then `bin`=9999 → 0,0,0,0 with `ovf`=0; then 9,9,9,9 with `ovf`=0.
- `bin`=16383 → `ovf`=1. Digits are 9,9,9,9 with `BCD_SATURATE_EN` and 6,3,8,3 without it.
- `bin`=1234 accepted, then `start` pulses at E5 with `bin`=4321 → that `start` is ignored; the result is 1,2,3,4 and exactly one `done` pulse.
- Convert 5678, then assert `rst` at E7 of a conversion of 4321 → outputs 0,0,0,0, no `done`. A following `start` with 4321 yields 4,3,2,1.
- Back-to-back: `start` held high continuously with `bin`=256 → 0,2,5,6, with `done` pulses exactly 16 cycles apart.
